// File: rtl/lcd_stream_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : lcd_stream_ctrl                                         |
// | Brief    : 8-bit parallel LCD bring-up and test-pattern streamer   |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module lcd_stream_ctrl #(
  parameter int H_RES    = 48,
  parameter int V_RES    = 640,
  parameter int X_OFS    = 0,
  parameter int Y_OFS    = 0,
  parameter int WR_HALF  = 1,
  parameter int RST_LOW  = 120000,
  parameter int RST_WAIT = 1440000,
  parameter int SLP_WAIT = 1440000
) (
  input  logic       i_clk,
  input  logic       i_res_n,
  input  logic       i_frame_en,
  input  logic [1:0] i_mode,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_wr,
  output logic       o_lcd_dc,
  output logic       o_lcd_rst,
  output logic       o_frame_start
);

  typedef enum logic [2:0] {
    ST_RST_ASSERT = 3'd0,
    ST_RST_WAIT   = 3'd1,
    ST_INIT       = 3'd2,
    ST_IDLE       = 3'd3,
    ST_WIN        = 3'd4,
    ST_PIXEL      = 3'd5
  } state_t;

  localparam logic [31:0] c_last_ph   = 32'(2 * WR_HALF - 1);
  localparam logic [31:0] c_wr_half   = 32'(WR_HALF);
  localparam logic [31:0] c_rst_last  = 32'(RST_LOW - 1);
  localparam logic [31:0] c_wait_last = 32'(RST_WAIT - 1);
  localparam logic [31:0] c_slp_last  = 32'(SLP_WAIT - 1);
  localparam logic [9:0]  c_x_last    = 10'(H_RES - 1);
  localparam logic [9:0]  c_y_last    = 10'(V_RES - 1);
  localparam logic [9:0]  c_bar_last  = 10'(((H_RES / 8) > 1 ? (H_RES / 8) : 1) - 1);
  localparam logic [15:0] c_xs        = 16'(X_OFS);
  localparam logic [15:0] c_xe        = 16'(X_OFS + H_RES - 1);
  localparam logic [15:0] c_ys        = 16'(Y_OFS);
  localparam logic [15:0] c_ye        = 16'(Y_OFS + V_RES - 1);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_cnt, w_cnt_nxt;
  logic [3:0]  r_idx, w_idx_nxt;
  logic [9:0]  r_x, w_x_nxt, r_y, w_y_nxt, r_bar_cnt, w_bar_cnt_nxt;
  logic [2:0]  r_bar, w_bar_nxt;
  logic        r_lo, w_lo_nxt;
  logic [1:0]  r_mode, w_mode_nxt;
  logic        w_byte_done;

  logic [15:0] w_color;
  logic        w_sending;
  logic [7:0]  w_data, r_data;
  logic        w_wr, w_dc, w_rst, w_fs;
  logic        r_wr, r_dc, r_rst, r_fs;

  assign w_byte_done = (r_cnt == c_last_ph);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + 32'd1;
    w_idx_nxt     = r_idx;
    w_x_nxt       = r_x;
    w_y_nxt       = r_y;
    w_bar_nxt     = r_bar;
    w_bar_cnt_nxt = r_bar_cnt;
    w_lo_nxt      = r_lo;
    w_mode_nxt    = r_mode;
    case (r_state)
      ST_RST_ASSERT: if (r_cnt == c_rst_last) begin
        w_state_nxt = ST_RST_WAIT;
        w_cnt_nxt   = '0;
      end
      ST_RST_WAIT: if (r_cnt == c_wait_last) begin
        w_state_nxt = ST_INIT;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
      end
      ST_INIT: begin
        // step 1 is the sleep-out wait between 0x11 and the pixel-format command
        if (r_idx == 4'd1) begin
          if (r_cnt == c_slp_last) begin
            w_idx_nxt = 4'd2;
            w_cnt_nxt = '0;
          end
        end else if (w_byte_done) begin
          w_cnt_nxt = '0;
          if (r_idx == 4'd4) w_state_nxt = ST_IDLE;
          else               w_idx_nxt   = r_idx + 4'd1;
        end
      end
      ST_IDLE: begin
        w_cnt_nxt = '0;
        w_idx_nxt = '0;
        if (i_frame_en) begin
          w_state_nxt = ST_WIN;
          w_mode_nxt  = i_mode;
        end
      end
      ST_WIN: if (w_byte_done) begin
        w_cnt_nxt = '0;
        if (r_idx == 4'd10) begin
          w_state_nxt   = ST_PIXEL;
          w_x_nxt       = '0;
          w_y_nxt       = '0;
          w_lo_nxt      = 1'b0;
          w_bar_nxt     = '0;
          w_bar_cnt_nxt = '0;
        end else begin
          w_idx_nxt = r_idx + 4'd1;
        end
      end
      ST_PIXEL: if (w_byte_done) begin
        w_cnt_nxt = '0;
        w_lo_nxt  = ~r_lo;
        if (r_lo) begin
          if (r_x == c_x_last) begin
            w_x_nxt       = '0;
            w_bar_nxt     = '0;
            w_bar_cnt_nxt = '0;
            if (r_y == c_y_last) w_state_nxt = ST_IDLE;
            else                 w_y_nxt     = r_y + 10'd1;
          end else begin
            w_x_nxt = r_x + 10'd1;
            // bar index tracks x / bar_width without a divider
            if (r_bar_cnt == c_bar_last) begin
              w_bar_cnt_nxt = '0;
              if (r_bar != 3'd7) w_bar_nxt = r_bar + 3'd1;
            end else begin
              w_bar_cnt_nxt = r_bar_cnt + 10'd1;
            end
          end
        end
      end
      default: begin
        w_state_nxt = ST_RST_ASSERT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_color = 16'hFFFF;
    case (w_mode_nxt)
      2'd1: case (w_bar_nxt)
        3'd0:    w_color = 16'hFFFF;
        3'd1:    w_color = 16'hFFE0;
        3'd2:    w_color = 16'h07FF;
        3'd3:    w_color = 16'h07E0;
        3'd4:    w_color = 16'hF81F;
        3'd5:    w_color = 16'hF800;
        3'd6:    w_color = 16'h001F;
        default: w_color = 16'h0000;
      endcase
      2'd2:    w_color = (w_x_nxt[3] ^ w_y_nxt[3]) ? 16'h0000 : 16'hFFFF;
      2'd3:    w_color = {w_y_nxt[4:0], w_x_nxt[5:0], w_x_nxt[4:0]};
      default: w_color = 16'hFFFF;
    endcase
  end

  // Outputs are decoded from the next state so the pins come straight from flops
  always_comb begin
    w_rst     = 1'b1;
    w_wr      = 1'b1;
    w_dc      = 1'b0;
    w_data    = 8'h00;
    w_fs      = 1'b0;
    w_sending = 1'b0;
    case (w_state_nxt)
      ST_RST_ASSERT: w_rst = 1'b0;
      ST_INIT: begin
        w_sending = (w_idx_nxt != 4'd1);
        case (w_idx_nxt)
          4'd0:    w_data = 8'h11;
          4'd2:    w_data = 8'h3A;
          4'd3:    begin w_data = 8'h55; w_dc = 1'b1; end
          4'd4:    w_data = 8'h29;
          default: w_data = 8'h00;
        endcase
      end
      ST_WIN: begin
        w_sending = 1'b1;
        w_dc      = 1'b1;
        w_fs      = (w_idx_nxt == 4'd0) && (w_cnt_nxt == '0);
        case (w_idx_nxt)
          4'd0:    begin w_data = 8'h2A; w_dc = 1'b0; end
          4'd1:    w_data = c_xs[15:8];
          4'd2:    w_data = c_xs[7:0];
          4'd3:    w_data = c_xe[15:8];
          4'd4:    w_data = c_xe[7:0];
          4'd5:    begin w_data = 8'h2B; w_dc = 1'b0; end
          4'd6:    w_data = c_ys[15:8];
          4'd7:    w_data = c_ys[7:0];
          4'd8:    w_data = c_ye[15:8];
          4'd9:    w_data = c_ye[7:0];
          default: begin w_data = 8'h2C; w_dc = 1'b0; end
        endcase
      end
      ST_PIXEL: begin
        w_sending = 1'b1;
        w_dc      = 1'b1;
        w_data    = w_lo_nxt ? w_color[7:0] : w_color[15:8];
      end
      default: w_rst = 1'b1;
    endcase
    if (w_sending) w_wr = (w_cnt_nxt >= c_wr_half);
  end

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      r_state   <= ST_RST_ASSERT;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_bar     <= '0;
      r_bar_cnt <= '0;
      r_lo      <= 1'b0;
      r_mode    <= '0;
      r_rst     <= 1'b0;
      r_wr      <= 1'b1;
      r_dc      <= 1'b0;
      r_data    <= 8'h00;
      r_fs      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_x       <= w_x_nxt;
      r_y       <= w_y_nxt;
      r_bar     <= w_bar_nxt;
      r_bar_cnt <= w_bar_cnt_nxt;
      r_lo      <= w_lo_nxt;
      r_mode    <= w_mode_nxt;
      r_rst     <= w_rst;
      r_wr      <= w_wr;
      r_dc      <= w_dc;
      r_data    <= w_data;
      r_fs      <= w_fs;
    end
  end

  assign o_lcd_rst     = r_rst;
  assign o_lcd_wr      = r_wr;
  assign o_lcd_dc      = r_dc;
  assign o_lcd_data    = r_data;
  assign o_frame_start = r_fs;

endmodule
`default_nettype wire

// File: tb/tb_lcd_stream_ctrl.sv
`default_nettype none
// Directed bench: small 4x2 panel (dut_a) plus a 16x2 panel with offsets and
// WR_HALF=2 (dut_b); bytes are captured at each rising write strobe.
module tb_lcd_stream_ctrl;

  logic       clk = 1'b0;
  logic       res_n;
  logic       en_a, en_b;
  logic [1:0] mode_a, mode_b;
  logic [7:0] data_a, data_b;
  logic       wr_a, wr_b, dc_a, dc_b, rst_a, rst_b, fs_a, fs_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lcd_stream_ctrl #(
    .H_RES(4), .V_RES(2), .X_OFS(0), .Y_OFS(0), .WR_HALF(1),
    .RST_LOW(4), .RST_WAIT(4), .SLP_WAIT(4)
  ) dut_a (
    .i_clk(clk), .i_res_n(res_n), .i_frame_en(en_a), .i_mode(mode_a),
    .o_lcd_data(data_a), .o_lcd_wr(wr_a), .o_lcd_dc(dc_a),
    .o_lcd_rst(rst_a), .o_frame_start(fs_a)
  );

  lcd_stream_ctrl #(
    .H_RES(16), .V_RES(2), .X_OFS(5), .Y_OFS(3), .WR_HALF(2),
    .RST_LOW(4), .RST_WAIT(4), .SLP_WAIT(4)
  ) dut_b (
    .i_clk(clk), .i_res_n(res_n), .i_frame_en(en_b), .i_mode(mode_b),
    .o_lcd_data(data_b), .o_lcd_wr(wr_b), .o_lcd_dc(dc_b),
    .o_lcd_rst(rst_b), .o_frame_start(fs_b)
  );

  int         cyc = 0;
  logic       prev_a = 1'b1, prev_b = 1'b1;
  logic [8:0] q_a[$], q_b[$];
  int         t_a[$], t_b[$];
  int         fs_cnt_a = 0, fs_cnt_b = 0;

  always @(negedge clk) begin
    cyc++;
    if (res_n) begin
      if (wr_a && !prev_a) begin q_a.push_back({dc_a, data_a}); t_a.push_back(cyc); end
      if (wr_b && !prev_b) begin q_b.push_back({dc_b, data_b}); t_b.push_back(cyc); end
      if (fs_a) fs_cnt_a++;
      if (fs_b) fs_cnt_b++;
    end
    prev_a = wr_a;
    prev_b = wr_b;
  end

  task automatic test_reset();
    res_n = 1'b1; en_a = 1'b0; en_b = 1'b0; mode_a = 2'd0; mode_b = 2'd0;
    #3 res_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (rst_a !== 1'b0)   begin bad++; $display("FAIL reset_rst got=%b exp=0", rst_a); end
    total++; if (wr_a !== 1'b1)    begin bad++; $display("FAIL reset_wr got=%b exp=1", wr_a); end
    total++; if (dc_a !== 1'b0)    begin bad++; $display("FAIL reset_dc got=%b exp=0", dc_a); end
    total++; if (data_a !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data_a); end
    total++; if (fs_a !== 1'b0)    begin bad++; $display("FAIL reset_fs got=%b exp=0", fs_a); end
    total++; if (rst_b !== 1'b0)   begin bad++; $display("FAIL reset_rst_b got=%b exp=0", rst_b); end
  endtask

  // per-cycle {rst, wr, dc, data} from reset release to the first IDLE cycle
  task automatic test_init();
    logic [10:0] exp_tr [21] = '{
      11'h200, 11'h200, 11'h200, 11'h200,
      11'h600, 11'h600, 11'h600, 11'h600,
      11'h411, 11'h611,
      11'h600, 11'h600, 11'h600, 11'h600,
      11'h43A, 11'h63A, 11'h555, 11'h755, 11'h429, 11'h629,
      11'h600 };
    @(posedge clk);
    #1 res_n = 1'b1;
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      total++;
      if ({rst_a, wr_a, dc_a, data_a} !== exp_tr[c]) begin
        bad++;
        $display("FAIL init_cycle%0d got=%h exp=%h", c, {rst_a, wr_a, dc_a, data_a}, exp_tr[c]);
      end
    end
  endtask

  task automatic test_frame_mode0();
    logic [8:0] exp_win [11] = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h103,
                                 9'h02B, 9'h100, 9'h100, 9'h100, 9'h101, 9'h02C};
    int n;
    q_a.delete(); t_a.delete(); fs_cnt_a = 0;
    en_a = 1'b1; mode_a = 2'd0;
    n = 0;
    while (fs_a !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    total++; if (fs_a !== 1'b1) begin bad++; $display("FAIL frame0_start got=%b exp=1", fs_a); end
    total++; if ({wr_a, dc_a, data_a} !== 10'h02A) begin
      bad++; $display("FAIL frame0_first_byte got=%h exp=02a", {wr_a, dc_a, data_a});
    end
    en_a = 1'b0;
    n = 0;
    while (q_a.size() < 27 && n < 200) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    total++;
    if (q_a.size() != 27) begin
      bad++; $display("FAIL frame0_bytes got=%0d exp=27", q_a.size());
    end else begin
      for (int i = 0; i < 27; i++) begin
        total++;
        if (q_a[i] !== ((i < 11) ? exp_win[i] : 9'h1FF)) begin
          bad++; $display("FAIL frame0_byte%0d got=%h exp=%h", i, q_a[i], (i < 11) ? exp_win[i] : 9'h1FF);
        end
      end
    end
    total++; if (fs_cnt_a != 1) begin bad++; $display("FAIL frame0_fs_count got=%0d exp=1", fs_cnt_a); end
  endtask

  task automatic test_back_to_back();
    int n;
    q_a.delete(); t_a.delete(); fs_cnt_a = 0;
    en_a = 1'b1; mode_a = 2'd0;
    n = 0;
    while (fs_cnt_a < 2 && n < 200) begin @(negedge clk); n++; end
    total++; if (fs_cnt_a < 2) begin bad++; $display("FAIL b2b_second_frame got=%0d exp=2", fs_cnt_a); end
    repeat (30) @(negedge clk);
    en_a = 1'b0;
    n = 0;
    while (q_a.size() < 54 && n < 200) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    total++;
    if (q_a.size() != 54) begin
      bad++; $display("FAIL b2b_bytes got=%0d exp=54", q_a.size());
    end else begin
      total++; if (q_a[26] !== 9'h1FF) begin bad++; $display("FAIL b2b_last_pix1 got=%h exp=1ff", q_a[26]); end
      total++; if (q_a[27] !== 9'h02A) begin bad++; $display("FAIL b2b_next_2a got=%h exp=02a", q_a[27]); end
      total++; if (t_a[27] - t_a[26] != 3) begin bad++; $display("FAIL b2b_gap got=%0d exp=3", t_a[27] - t_a[26]); end
      total++; if (t_a[26] - t_a[25] != 2) begin bad++; $display("FAIL b2b_pitch got=%0d exp=2", t_a[26] - t_a[25]); end
      total++; if (q_a[53] !== 9'h1FF) begin bad++; $display("FAIL stop_last_pix got=%h exp=1ff", q_a[53]); end
    end
    total++; if (fs_cnt_a != 2) begin bad++; $display("FAIL stop_fs_count got=%0d exp=2", fs_cnt_a); end
    total++; if ({wr_a, dc_a} !== 2'b10) begin bad++; $display("FAIL stop_idle got=%b exp=10", {wr_a, dc_a}); end
  endtask

  task automatic test_mode_latch();
    int         n;
    int         px_idx [4] = '{0, 3, 5, 7};
    logic [15:0] px_exp [4] = '{16'h0000, 16'h0063, 16'h0821, 16'h0863};
    logic [17:0] pix;
    q_a.delete(); t_a.delete();
    en_a = 1'b1; mode_a = 2'd0;
    n = 0;
    while (fs_a !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    en_a = 1'b0;
    repeat (25) @(negedge clk);
    mode_a = 2'd3;
    n = 0;
    while (q_a.size() < 27 && n < 200) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    total++;
    if (q_a.size() != 27) begin
      bad++; $display("FAIL latch_bytes got=%0d exp=27", q_a.size());
    end else begin
      for (int i = 11; i < 27; i++) begin
        total++;
        if (q_a[i] !== 9'h1FF) begin bad++; $display("FAIL latch_mode0_byte%0d got=%h exp=1ff", i, q_a[i]); end
      end
    end
    q_a.delete(); t_a.delete();
    en_a = 1'b1;
    n = 0;
    while (fs_a !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    en_a = 1'b0; mode_a = 2'd0;
    n = 0;
    while (q_a.size() < 27 && n < 200) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    total++;
    if (q_a.size() != 27) begin
      bad++; $display("FAIL grad_bytes got=%0d exp=27", q_a.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        pix = {q_a[11 + 2 * px_idx[k]], q_a[12 + 2 * px_idx[k]]};
        total++;
        if (pix !== {1'b1, px_exp[k][15:8], 1'b1, px_exp[k][7:0]}) begin
          bad++; $display("FAIL grad_pix%0d got=%h exp=%h", px_idx[k], pix, {1'b1, px_exp[k][15:8], 1'b1, px_exp[k][7:0]});
        end
      end
    end
  endtask

  task automatic test_bars();
    int          n;
    logic [8:0]  exp_win [11] = '{9'h02A, 9'h100, 9'h105, 9'h100, 9'h114,
                                  9'h02B, 9'h100, 9'h103, 9'h100, 9'h104, 9'h02C};
    int          px_idx [5] = '{2, 5, 13, 15, 16};
    logic [15:0] px_exp [5] = '{16'hFFE0, 16'h07FF, 16'h001F, 16'h0000, 16'hFFFF};
    logic [17:0] pix;
    q_b.delete(); t_b.delete(); fs_cnt_b = 0;
    en_b = 1'b1; mode_b = 2'd1;
    n = 0;
    while (fs_b !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    en_b = 1'b0;
    total++; if (wr_b !== 1'b0) begin bad++; $display("FAIL bars_wr_ph0 got=%b exp=0", wr_b); end
    @(negedge clk);
    total++; if (wr_b !== 1'b0) begin bad++; $display("FAIL bars_wr_ph1 got=%b exp=0", wr_b); end
    @(negedge clk);
    total++; if (wr_b !== 1'b1) begin bad++; $display("FAIL bars_wr_ph2 got=%b exp=1", wr_b); end
    n = 0;
    while (q_b.size() < 75 && n < 600) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    total++;
    if (q_b.size() != 75) begin
      bad++; $display("FAIL bars_bytes got=%0d exp=75", q_b.size());
    end else begin
      for (int i = 0; i < 11; i++) begin
        total++;
        if (q_b[i] !== exp_win[i]) begin bad++; $display("FAIL bars_win%0d got=%h exp=%h", i, q_b[i], exp_win[i]); end
      end
      for (int k = 0; k < 5; k++) begin
        pix = {q_b[11 + 2 * px_idx[k]], q_b[12 + 2 * px_idx[k]]};
        total++;
        if (pix !== {1'b1, px_exp[k][15:8], 1'b1, px_exp[k][7:0]}) begin
          bad++; $display("FAIL bars_pix%0d got=%h exp=%h", px_idx[k], pix, {1'b1, px_exp[k][15:8], 1'b1, px_exp[k][7:0]});
        end
      end
      total++; if (t_b[1] - t_b[0] != 4) begin bad++; $display("FAIL bars_pitch got=%0d exp=4", t_b[1] - t_b[0]); end
    end
    total++; if (fs_cnt_b != 1) begin bad++; $display("FAIL bars_fs_count got=%0d exp=1", fs_cnt_b); end
  endtask

  task automatic test_checker();
    int          n;
    int          px_idx [4] = '{7, 8, 16, 24};
    logic [15:0] px_exp [4] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
    logic [17:0] pix;
    q_b.delete(); t_b.delete();
    en_b = 1'b1; mode_b = 2'd2;
    n = 0;
    while (fs_b !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    en_b = 1'b0;
    n = 0;
    while (q_b.size() < 75 && n < 600) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    total++;
    if (q_b.size() != 75) begin
      bad++; $display("FAIL chk_bytes got=%0d exp=75", q_b.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        pix = {q_b[11 + 2 * px_idx[k]], q_b[12 + 2 * px_idx[k]]};
        total++;
        if (pix !== {1'b1, px_exp[k][15:8], 1'b1, px_exp[k][7:0]}) begin
          bad++; $display("FAIL chk_pix%0d got=%h exp=%h", px_idx[k], pix, {1'b1, px_exp[k][15:8], 1'b1, px_exp[k][7:0]});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    en_a = 1'b1; mode_a = 2'd0;
    n = 0;
    while (fs_a !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    repeat (30) @(negedge clk);
    total++; if (dc_a !== 1'b1) begin bad++; $display("FAIL midrst_in_pixel got=%b exp=1", dc_a); end
    @(posedge clk);
    #1 res_n = 1'b0;
    #1;
    total++; if (rst_a !== 1'b0)   begin bad++; $display("FAIL midrst_rst got=%b exp=0", rst_a); end
    total++; if (wr_a !== 1'b1)    begin bad++; $display("FAIL midrst_wr got=%b exp=1", wr_a); end
    total++; if (dc_a !== 1'b0)    begin bad++; $display("FAIL midrst_dc got=%b exp=0", dc_a); end
    total++; if (data_a !== 8'h00) begin bad++; $display("FAIL midrst_data got=%h exp=00", data_a); end
    total++; if (fs_a !== 1'b0)    begin bad++; $display("FAIL midrst_fs got=%b exp=0", fs_a); end
    en_a = 1'b0;
    repeat (3) @(negedge clk);
    test_init();
  endtask

  initial begin
    test_reset();
    test_init();
    test_frame_mode0();
    test_back_to_back();
    test_mode_latch();
    test_bars();
    test_checker();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
